axi_burst_check_master: RTL and testbench
=========================================

Name: axi_burst_check_master

Overview:
AXI4 burst master that sits directly upstream of the dual-port AXI RAM slave. It drives the slave's AW/W/B and AR/R channels. On each start it writes one INCR burst of a deterministic data pattern, then reads the same burst back and compares every beat. It reports pass/fail status and a mismatch count; it is used for bring-up and self-test of the memory subsystem.

Parameters:
AXI_DATA_WIDTH, 64, data bus width in bits (power of 2, at least 8)
AXI_ID_WIDTH, 8, ID width in bits
AXI_ADDR_WIDTH, 12, byte address width
AXI_STRB_WIDTH, AXI_DATA_WIDTH/8, strobe width (derived)
TIMEOUT_CYCLES, 1024, maximum cycles waiting on any single handshake before abort

Ports:
axi_clk  in  1  clock, all logic on rising edge
axi_resetn  in  1  reset, asynchronous, active-low
start  in  1  single-cycle request; ignored while busy=1
cfg_addr  in  AXI_ADDR_WIDTH  start byte address; low log2(AXI_STRB_WIDTH) bits are forced to 0 on capture
cfg_len  in  8  AXI len (beats-1)
cfg_id  in  AXI_ID_WIDTH  ID used for AW and AR
cfg_seed  in  AXI_DATA_WIDTH  pattern seed
busy  out  1  high from start acceptance until done
done  out  1  one-cycle pulse at end of test
error  out  1  sticky fail flag, cleared on next accepted start
err_count  out  16  saturating count of read-data mismatches
axi_aw_addr/id/len/burst/size/valid  out  ADDR/ID/8/2/3/1  write address channel
axi_aw_ready  in  1
axi_w_data/strb/last/valid  out  DATA/STRB/1/1  write data channel
axi_w_ready  in  1
axi_b_id/resp/valid  in  ID/2/1; axi_b_ready  out  1
axi_ar_addr/id/len/burst/size/valid  out  ADDR/ID/8/2/3/1  read address channel
axi_ar_ready  in  1
axi_r_data/id/resp/last/valid  in  DATA/ID/2/1/1; axi_r_ready  out  1

Behaviour:
- Reset: state IDLE; all valid/ready outputs 0; busy, done, error 0; err_count 0; address/len/id/data outputs 0. Reset mid-burst aborts immediately with no drain.
- Config is captured on start&&IDLE. busy rises the next cycle. burst=2'b01 (INCR), size=log2(AXI_STRB_WIDTH), strb all ones.
- Pattern: beat i (0..len) data = seed + i, modulo 2^AXI_DATA_WIDTH.
- FSM states and transitions:
  - IDLE: on start, go to WA.
  - WA: aw_valid=1 until aw_valid&&aw_ready, then WD.
  - WD: w_valid=1; beat counter advances on each w handshake. w_last=1 when beat==len. After the last handshake, go to WB.
  - WB: wait for b_valid. If b_id!=cfg_id or b_resp!=0, set error. Then go to RA.
  - RA: ar_valid=1 until handshake, then RD.
  - RD: compare each r beat (r_valid&&r_ready) with the expected pattern. A data mismatch increments err_count (saturating at 16'hFFFF) and sets error. r_resp!=0 or r_id!=cfg_id sets error. r_last must equal (beat==len); a mismatch sets error. The beat with r_last, or beat==len, goes to DONE.
  - DONE: done=1 for one cycle, busy=0, then IDLE.
- axi_b_ready=1 in WA, WD and WB. The slave gates its write pipeline and aw_ready on b_ready, so it must be high throughout the write phase.
- axi_r_ready=1 in RA and RD.
- Valid outputs never drop before their handshake; payload is stable while valid=1.
- Timeout: a counter resets on every handshake and on each state entry. If it reaches TIMEOUT_CYCLES in WA, WD, WB, RA or RD, set error, drop all valids and go to DONE.
- Extra b_valid or r_valid outside WB/RD is ignored (ready=0).
- Address wrap past 2^AXI_ADDR_WIDTH is the slave's responsibility; the master issues the burst unchanged.

Test Plan:
- Single beat: addr=0x040, len=0, seed=0x11 -> one W beat with data 0x11 and w_last=1; read returns 0x11; done after B and R; error=0, err_count=0.
- 16-beat burst: addr=0x100, len=15, seed=0xA5A5_0000_0000_0000 -> read beats equal seed+0..15; r_last only on beat 15; error=0.
- Seed wraps: seed=0xFFFF_FFFF_FFFF_FFFE, len=3 -> data FE, FF, 0, 1 (64-bit wrap); pass.
- Fault injection: bench-model slave corrupts read beat 2 of len=7 -> err_count=1, error=1, done pulses.
- Stall: slave holds aw_ready=0 for 1100 cycles -> timeout; error=1, done pulse, aw_valid=0 afterward.
- Reset asserted in RD mid-burst -> all outputs 0 at once. A restart after release passes, and start pulses while busy are ignored.

Source files
------------

// File: rtl/axi_burst_check_master.sv
// ---------------------------------------------------------------------------
// axi_burst_check_master
//
// Self-test AXI4 master for the dual-port AXI RAM slave. On each accepted
// start it writes one INCR burst whose beat i carries (seed + i), then reads
// the same burst back and compares every beat against the same pattern.
// Results: sticky error flag, saturating mismatch counter, one-cycle done.
//
// Ports
//   axi_clk, axi_resetn      clock (rising edge) / async active-low reset
//   start                    single-cycle request, ignored while busy
//   cfg_addr/len/id/seed     burst configuration, captured on accepted start
//   busy, done               activity flag / end-of-test pulse
//   error, err_count         sticky fail flag / read-data mismatch count
//   axi_aw_*, axi_w_*, axi_b_*   write address, data and response channels
//   axi_ar_*, axi_r_*            read address and data channels
// ---------------------------------------------------------------------------
module axi_burst_check_master #(
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ID_WIDTH   = 8,
    parameter int AXI_ADDR_WIDTH = 12,
    parameter int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      axi_clk,
    input  logic                      axi_resetn,

    input  logic                      start,
    input  logic [AXI_ADDR_WIDTH-1:0] cfg_addr,
    input  logic [7:0]                cfg_len,
    input  logic [AXI_ID_WIDTH-1:0]   cfg_id,
    input  logic [AXI_DATA_WIDTH-1:0] cfg_seed,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    output logic [15:0]               err_count,

    output logic [AXI_ADDR_WIDTH-1:0] axi_aw_addr,
    output logic [AXI_ID_WIDTH-1:0]   axi_aw_id,
    output logic [7:0]                axi_aw_len,
    output logic [1:0]                axi_aw_burst,
    output logic [2:0]                axi_aw_size,
    output logic                      axi_aw_valid,
    input  logic                      axi_aw_ready,

    output logic [AXI_DATA_WIDTH-1:0] axi_w_data,
    output logic [AXI_STRB_WIDTH-1:0] axi_w_strb,
    output logic                      axi_w_last,
    output logic                      axi_w_valid,
    input  logic                      axi_w_ready,

    input  logic [AXI_ID_WIDTH-1:0]   axi_b_id,
    input  logic [1:0]                axi_b_resp,
    input  logic                      axi_b_valid,
    output logic                      axi_b_ready,

    output logic [AXI_ADDR_WIDTH-1:0] axi_ar_addr,
    output logic [AXI_ID_WIDTH-1:0]   axi_ar_id,
    output logic [7:0]                axi_ar_len,
    output logic [1:0]                axi_ar_burst,
    output logic [2:0]                axi_ar_size,
    output logic                      axi_ar_valid,
    input  logic                      axi_ar_ready,

    input  logic [AXI_DATA_WIDTH-1:0] axi_r_data,
    input  logic [AXI_ID_WIDTH-1:0]   axi_r_id,
    input  logic [1:0]                axi_r_resp,
    input  logic                      axi_r_last,
    input  logic                      axi_r_valid,
    output logic                      axi_r_ready
);

    localparam int                        SIZE_LSB  = $clog2(AXI_STRB_WIDTH);
    localparam logic [2:0]                AXI_SIZE  = 3'(SIZE_LSB);
    // Clears the sub-beat byte offset so every burst is bus-aligned.
    localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_MASK =
        ~(AXI_ADDR_WIDTH'((64'd1 << SIZE_LSB) - 64'd1));
    localparam int                        TO_W      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0]           TO_LIMIT  = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WA   = 3'd1,
        ST_WD   = 3'd2,
        ST_WB   = 3'd3,
        ST_RA   = 3'd4,
        ST_RD   = 3'd5,
        ST_DONE = 3'd6
    } state_t;

    state_t                      state_r;
    state_t                      state_nxt_s;

    logic [AXI_ADDR_WIDTH-1:0]   addr_r;
    logic [AXI_ID_WIDTH-1:0]     id_r;
    logic [7:0]                  len_r;
    logic [AXI_DATA_WIDTH-1:0]   seed_r;
    logic [1:0]                  burst_r;
    logic [2:0]                  size_r;
    logic [AXI_STRB_WIDTH-1:0]   strb_r;

    logic [7:0]                  beat_r;
    logic [AXI_DATA_WIDTH-1:0]   pat_r;
    logic                        w_last_r;

    logic                        aw_valid_r;
    logic                        w_valid_r;
    logic                        b_ready_r;
    logic                        ar_valid_r;
    logic                        r_ready_r;
    logic                        busy_r;
    logic                        done_r;
    logic                        error_r;
    logic [15:0]                 err_count_r;
    logic [TO_W-1:0]             to_cnt_r;

    logic                        start_acc_s;
    logic                        aw_hs_s;
    logic                        w_hs_s;
    logic                        b_hs_s;
    logic                        ar_hs_s;
    logic                        r_hs_s;
    logic                        any_hs_s;
    logic                        to_expired_s;
    logic                        timeout_s;
    logic                        err_set_s;
    logic                        mismatch_s;

    // Handshake qualifiers; B and R only count in the states that consume them,
    // so stray responses elsewhere are ignored.
    assign start_acc_s  = start && (state_r == ST_IDLE);
    assign aw_hs_s      = aw_valid_r && axi_aw_ready;
    assign w_hs_s       = w_valid_r && axi_w_ready;
    assign b_hs_s       = b_ready_r && axi_b_valid && (state_r == ST_WB);
    assign ar_hs_s      = ar_valid_r && axi_ar_ready;
    assign r_hs_s       = r_ready_r && axi_r_valid && (state_r == ST_RD);
    assign any_hs_s     = aw_hs_s || w_hs_s || b_hs_s || ar_hs_s || r_hs_s;
    assign to_expired_s = (to_cnt_r >= TO_LIMIT);

    // State register.
    always_ff @(posedge axi_clk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; a handshake always wins over a same-cycle timeout.
    always_comb begin
        state_nxt_s = state_r;
        timeout_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_WA;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WA: begin
                if (aw_hs_s) begin
                    state_nxt_s = ST_WD;
                end else if (to_expired_s) begin
                    state_nxt_s = ST_DONE;
                    timeout_s   = 1'b1;
                end else begin
                    state_nxt_s = ST_WA;
                end
            end
            ST_WD: begin
                if (w_hs_s && w_last_r) begin
                    state_nxt_s = ST_WB;
                end else if (!w_hs_s && to_expired_s) begin
                    state_nxt_s = ST_DONE;
                    timeout_s   = 1'b1;
                end else begin
                    state_nxt_s = ST_WD;
                end
            end
            ST_WB: begin
                if (b_hs_s) begin
                    state_nxt_s = ST_RA;
                end else if (to_expired_s) begin
                    state_nxt_s = ST_DONE;
                    timeout_s   = 1'b1;
                end else begin
                    state_nxt_s = ST_WB;
                end
            end
            ST_RA: begin
                if (ar_hs_s) begin
                    state_nxt_s = ST_RD;
                end else if (to_expired_s) begin
                    state_nxt_s = ST_DONE;
                    timeout_s   = 1'b1;
                end else begin
                    state_nxt_s = ST_RA;
                end
            end
            ST_RD: begin
                if (r_hs_s) begin
                    if (axi_r_last || (beat_r == len_r)) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_RD;
                    end
                end else if (to_expired_s) begin
                    state_nxt_s = ST_DONE;
                    timeout_s   = 1'b1;
                end else begin
                    state_nxt_s = ST_RD;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Error detection for the current cycle: timeout, bad B response, bad R beat.
    always_comb begin
        err_set_s  = 1'b0;
        mismatch_s = 1'b0;
        if (timeout_s) begin
            err_set_s = 1'b1;
        end else if (b_hs_s) begin
            err_set_s = (axi_b_id != id_r) || (axi_b_resp != 2'b00);
        end else if (r_hs_s) begin
            mismatch_s = (axi_r_data != pat_r);
            err_set_s  = mismatch_s || (axi_r_resp != 2'b00) || (axi_r_id != id_r) ||
                         (axi_r_last != (beat_r == len_r));
        end else begin
            err_set_s  = 1'b0;
            mismatch_s = 1'b0;
        end
    end

    // Handshake watchdog: restarts on every handshake and on every state change.
    always_ff @(posedge axi_clk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            to_cnt_r <= {TO_W{1'b0}};
        end else if ((state_nxt_s != state_r) || any_hs_s) begin
            to_cnt_r <= {TO_W{1'b0}};
        end else if (busy_r && !to_expired_s) begin
            to_cnt_r <= to_cnt_r + TO_W'(1);
        end else if (!busy_r) begin
            to_cnt_r <= {TO_W{1'b0}};
        end
    end

    // Configuration capture on an accepted start.
    always_ff @(posedge axi_clk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            addr_r  <= {AXI_ADDR_WIDTH{1'b0}};
            id_r    <= {AXI_ID_WIDTH{1'b0}};
            len_r   <= 8'd0;
            seed_r  <= {AXI_DATA_WIDTH{1'b0}};
            burst_r <= 2'b00;
            size_r  <= 3'd0;
            strb_r  <= {AXI_STRB_WIDTH{1'b0}};
        end else if (start_acc_s) begin
            addr_r  <= cfg_addr & ADDR_MASK;
            id_r    <= cfg_id;
            len_r   <= cfg_len;
            seed_r  <= cfg_seed;
            burst_r <= 2'b01;
            size_r  <= AXI_SIZE;
            strb_r  <= {AXI_STRB_WIDTH{1'b1}};
        end
    end

    // Beat counter and pattern generator, shared by the write and read phases.
    // The pattern only advances on a handshake, keeping w_data stable under valid.
    always_ff @(posedge axi_clk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            beat_r   <= 8'd0;
            pat_r    <= {AXI_DATA_WIDTH{1'b0}};
            w_last_r <= 1'b0;
        end else if (((state_r == ST_WA) && (state_nxt_s == ST_WD)) ||
                     ((state_r == ST_RA) && (state_nxt_s == ST_RD))) begin
            beat_r   <= 8'd0;
            pat_r    <= seed_r;
            w_last_r <= (state_nxt_s == ST_WD) && (len_r == 8'd0);
        end else if (w_hs_s || r_hs_s) begin
            beat_r   <= beat_r + 8'd1;
            pat_r    <= pat_r + AXI_DATA_WIDTH'(1);
            w_last_r <= w_hs_s && !w_last_r && ((beat_r + 8'd1) == len_r);
        end else begin
            w_last_r <= w_last_r && (state_nxt_s == ST_WD);
        end
    end

    // Sticky error flag and saturating mismatch counter, cleared on a new start.
    always_ff @(posedge axi_clk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            error_r     <= 1'b0;
            err_count_r <= 16'd0;
        end else if (start_acc_s) begin
            error_r     <= 1'b0;
            err_count_r <= 16'd0;
        end else begin
            if (err_set_s) begin
                error_r <= 1'b1;
            end
            if (mismatch_s && (err_count_r != 16'hFFFF)) begin
                err_count_r <= err_count_r + 16'd1;
            end
        end
    end

    // Channel controls decoded from the next state so they are registered and
    // line up exactly with the state they belong to.
    always_ff @(posedge axi_clk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            aw_valid_r <= 1'b0;
            w_valid_r  <= 1'b0;
            b_ready_r  <= 1'b0;
            ar_valid_r <= 1'b0;
            r_ready_r  <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            aw_valid_r <= (state_nxt_s == ST_WA);
            w_valid_r  <= (state_nxt_s == ST_WD);
            // The RAM slave gates aw_ready and its write pipe on b_ready.
            b_ready_r  <= (state_nxt_s == ST_WA) || (state_nxt_s == ST_WD) ||
                          (state_nxt_s == ST_WB);
            ar_valid_r <= (state_nxt_s == ST_RA);
            r_ready_r  <= (state_nxt_s == ST_RA) || (state_nxt_s == ST_RD);
            busy_r     <= (state_nxt_s != ST_IDLE) && (state_nxt_s != ST_DONE);
            done_r     <= (state_nxt_s == ST_DONE);
        end
    end

    assign busy         = busy_r;
    assign done         = done_r;
    assign error        = error_r;
    assign err_count    = err_count_r;

    assign axi_aw_addr  = addr_r;
    assign axi_aw_id    = id_r;
    assign axi_aw_len   = len_r;
    assign axi_aw_burst = burst_r;
    assign axi_aw_size  = size_r;
    assign axi_aw_valid = aw_valid_r;

    assign axi_w_data   = pat_r;
    assign axi_w_strb   = strb_r;
    assign axi_w_last   = w_last_r;
    assign axi_w_valid  = w_valid_r;

    assign axi_b_ready  = b_ready_r;

    assign axi_ar_addr  = addr_r;
    assign axi_ar_id    = id_r;
    assign axi_ar_len   = len_r;
    assign axi_ar_burst = burst_r;
    assign axi_ar_size  = size_r;
    assign axi_ar_valid = ar_valid_r;

    assign axi_r_ready  = r_ready_r;

endmodule

// File: tb/tb_axi_burst_check_master.sv
// ---------------------------------------------------------------------------
// Testbench for axi_burst_check_master. A behavioural AXI slave (word array
// plus randomised ready/valid timing) sits on the bus; expected results come
// from the pattern rule data[i] = seed + i and the injected faults.
// ---------------------------------------------------------------------------
module tb_axi_burst_check_master;

    localparam int DW = 64;
    localparam int IW = 8;
    localparam int AW = 12;
    localparam int SW = DW / 8;

    logic          axi_clk = 1'b0;
    logic          axi_resetn = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] cfg_addr = '0;
    logic [7:0]    cfg_len = '0;
    logic [IW-1:0] cfg_id = '0;
    logic [DW-1:0] cfg_seed = '0;
    logic          busy, done, error;
    logic [15:0]   err_count;
    logic [AW-1:0] axi_aw_addr, axi_ar_addr;
    logic [IW-1:0] axi_aw_id, axi_ar_id;
    logic [7:0]    axi_aw_len, axi_ar_len;
    logic [1:0]    axi_aw_burst, axi_ar_burst;
    logic [2:0]    axi_aw_size, axi_ar_size;
    logic          axi_aw_valid, axi_ar_valid;
    logic          axi_aw_ready = 1'b0, axi_ar_ready = 1'b0;
    logic [DW-1:0] axi_w_data;
    logic [SW-1:0] axi_w_strb;
    logic          axi_w_last, axi_w_valid;
    logic          axi_w_ready = 1'b0;
    logic [IW-1:0] axi_b_id = '0;
    logic [1:0]    axi_b_resp = '0;
    logic          axi_b_valid = 1'b0;
    logic          axi_b_ready;
    logic [DW-1:0] axi_r_data = '0;
    logic [IW-1:0] axi_r_id = '0;
    logic [1:0]    axi_r_resp = '0;
    logic          axi_r_last = 1'b0, axi_r_valid = 1'b0;
    logic          axi_r_ready;

    int vectors = 0;
    int miscompares = 0;

    // Slave model state
    logic [DW-1:0] mem [512];
    int            aw_cnt, w_cnt, ar_cnt, r_cnt, r_left, w_bad, aw_bad, ar_bad;
    int            wbase, rbase, stall_left, corrupt_beat;
    logic [7:0]    s_awlen;
    logic [IW-1:0] s_awid, s_arid;
    bit            b_pend, b_hs_prev, r_hs_prev, bad_resp, noise_on;
    logic [AW-1:0] exp_addr;
    logic [7:0]    exp_len;
    logic [IW-1:0] exp_id;

    always #5 axi_clk = ~axi_clk;

    axi_burst_check_master #(
        .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IW), .AXI_ADDR_WIDTH(AW),
        .AXI_STRB_WIDTH(SW), .TIMEOUT_CYCLES(1024)
    ) dut (
        .axi_clk(axi_clk), .axi_resetn(axi_resetn),
        .start(start), .cfg_addr(cfg_addr), .cfg_len(cfg_len), .cfg_id(cfg_id),
        .cfg_seed(cfg_seed), .busy(busy), .done(done), .error(error),
        .err_count(err_count),
        .axi_aw_addr(axi_aw_addr), .axi_aw_id(axi_aw_id), .axi_aw_len(axi_aw_len),
        .axi_aw_burst(axi_aw_burst), .axi_aw_size(axi_aw_size),
        .axi_aw_valid(axi_aw_valid), .axi_aw_ready(axi_aw_ready),
        .axi_w_data(axi_w_data), .axi_w_strb(axi_w_strb), .axi_w_last(axi_w_last),
        .axi_w_valid(axi_w_valid), .axi_w_ready(axi_w_ready),
        .axi_b_id(axi_b_id), .axi_b_resp(axi_b_resp), .axi_b_valid(axi_b_valid),
        .axi_b_ready(axi_b_ready),
        .axi_ar_addr(axi_ar_addr), .axi_ar_id(axi_ar_id), .axi_ar_len(axi_ar_len),
        .axi_ar_burst(axi_ar_burst), .axi_ar_size(axi_ar_size),
        .axi_ar_valid(axi_ar_valid), .axi_ar_ready(axi_ar_ready),
        .axi_r_data(axi_r_data), .axi_r_id(axi_r_id), .axi_r_resp(axi_r_resp),
        .axi_r_last(axi_r_last), .axi_r_valid(axi_r_valid), .axi_r_ready(axi_r_ready)
    );

    task automatic slave_reset();
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; r_cnt = 0; r_left = 0;
        w_bad = 0; aw_bad = 0; ar_bad = 0; wbase = 0; rbase = 0;
        stall_left = 0; corrupt_beat = -1; s_awlen = '0; s_awid = '0; s_arid = '0;
        b_pend = 0; b_hs_prev = 0; r_hs_prev = 0; bad_resp = 0; noise_on = 0;
        axi_aw_ready = 1'b0; axi_w_ready = 1'b0; axi_ar_ready = 1'b0;
        axi_b_valid = 1'b0; axi_b_id = '0; axi_b_resp = 2'b00;
        axi_r_valid = 1'b0; axi_r_data = '0; axi_r_id = '0; axi_r_resp = 2'b00;
        axi_r_last = 1'b0;
    endtask

    // One slave cycle, called at a negedge: retire last cycle's handshakes,
    // drive new slave signals, then note handshakes that the coming posedge takes.
    task automatic slave_step();
        if (b_hs_prev) begin axi_b_valid = 1'b0; b_hs_prev = 0; end
        if (r_hs_prev) begin axi_r_valid = 1'b0; axi_r_last = 1'b0; r_hs_prev = 0; end
        axi_aw_ready = (stall_left > 0) ? 1'b0 : ($urandom_range(0, 3) != 0);
        if (stall_left > 0) stall_left--;
        axi_w_ready  = ($urandom_range(0, 3) != 0);
        axi_ar_ready = ($urandom_range(0, 3) != 0);
        if (b_pend && !axi_b_valid && ($urandom_range(0, 1) == 1)) begin
            axi_b_valid = 1'b1;
            axi_b_id    = s_awid;
            axi_b_resp  = bad_resp ? 2'b10 : 2'b00;
            b_pend      = 0;
        end
        if ((r_left > 0) && !axi_r_valid && ($urandom_range(0, 3) != 0)) begin
            axi_r_valid = 1'b1;
            axi_r_data  = mem[(rbase + r_cnt) % 512];
            if (r_cnt == corrupt_beat) axi_r_data = axi_r_data ^ 64'h0000_0000_0000_0100;
            axi_r_id    = s_arid;
            axi_r_resp  = 2'b00;
            axi_r_last  = (r_left == 1);
        end
        if (noise_on && (busy === 1'b1) && ($urandom_range(0, 5) == 0)) begin
            start    = 1'b1;
            cfg_addr = AW'($urandom);
            cfg_len  = 8'($urandom);
            cfg_id   = IW'($urandom);
            cfg_seed = {$urandom, $urandom};
        end else begin
            start = 1'b0;
        end
        if (axi_aw_valid && axi_aw_ready) begin
            aw_cnt++;
            wbase   = int'(axi_aw_addr) / SW;
            s_awlen = axi_aw_len;
            s_awid  = axi_aw_id;
            if ({axi_aw_addr, axi_aw_len, axi_aw_id, axi_aw_burst, axi_aw_size} !==
                {exp_addr, exp_len, exp_id, 2'b01, 3'd3}) aw_bad++;
        end
        if (axi_w_valid && axi_w_ready) begin
            mem[(wbase + w_cnt) % 512] = axi_w_data;
            if (axi_w_last !== (w_cnt == int'(s_awlen))) w_bad++;
            if (axi_w_strb !== 8'hFF) w_bad++;
            w_cnt++;
            if (w_cnt == int'(s_awlen) + 1) b_pend = 1;
        end
        if (axi_b_valid && axi_b_ready) b_hs_prev = 1;
        if (axi_ar_valid && axi_ar_ready) begin
            ar_cnt++;
            rbase  = int'(axi_ar_addr) / SW;
            s_arid = axi_ar_id;
            r_left = int'(axi_ar_len) + 1;
            r_cnt  = 0;
            if ({axi_ar_addr, axi_ar_len, axi_ar_id, axi_ar_burst, axi_ar_size} !==
                {exp_addr, exp_len, exp_id, 2'b01, 3'd3}) ar_bad++;
        end
        if (axi_r_valid && axi_r_ready) begin
            r_hs_prev = 1;
            r_cnt++;
            r_left--;
        end
    endtask

    // Runs one complete self-test and checks it against the expected outcome.
    task automatic run_burst(input logic [AW-1:0] addr, input logic [7:0] len,
                             input logic [DW-1:0] seed, input int corrupt,
                             input int stall, input bit bresp_err, input bit noise,
                             input bit exp_timeout, input string name);
        bit            got_done;
        logic          exp_err;
        logic [15:0]   exp_cnt;
        logic [DW-1:0] exp_data;
        slave_reset();
        corrupt_beat = corrupt;
        stall_left   = stall;
        bad_resp     = bresp_err;
        exp_addr     = addr & 12'hFF8;
        exp_len      = len;
        exp_id       = IW'($urandom);
        exp_cnt      = ((corrupt >= 0) && (corrupt <= int'(len))) ? 16'd1 : 16'd0;
        exp_err      = exp_timeout || bresp_err || (exp_cnt != 16'd0);
        @(negedge axi_clk);
        start = 1'b1; cfg_addr = addr; cfg_len = len; cfg_id = exp_id; cfg_seed = seed;
        @(negedge axi_clk);
        start = 1'b0;
        noise_on = noise;
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL %s busy_rise: got %b want 1", name, busy);
        end
        got_done = 0;
        for (int c = 0; (c < 5000) && !got_done; c++) begin
            if (done === 1'b1) got_done = 1;
            else begin
                slave_step();
                @(negedge axi_clk);
            end
        end
        start = 1'b0;
        noise_on = 0;
        vectors++;
        if (!got_done) begin
            miscompares++;
            $display("FAIL %s done_seen: no done pulse within 5000 cycles", name);
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s busy_at_done: got %b want 0", name, busy);
        end
        @(negedge axi_clk);
        vectors++;
        if (done !== 1'b0) begin
            miscompares++;
            $display("FAIL %s done_width: got %b want 0 one cycle later", name, done);
        end
        vectors++;
        if (error !== exp_err) begin
            miscompares++;
            $display("FAIL %s error: got %b want %b", name, error, exp_err);
        end
        vectors++;
        if (err_count !== exp_cnt) begin
            miscompares++;
            $display("FAIL %s err_count: got %0d want %0d", name, err_count, exp_cnt);
        end
        vectors++;
        if ({aw_bad, ar_bad} !== 64'd0) begin
            miscompares++;
            $display("FAIL %s addr_fields: got %0d aw / %0d ar bad, want 0", name, aw_bad, ar_bad);
        end
        if (exp_timeout) begin
            vectors++;
            if ({axi_aw_valid, axi_w_valid, axi_ar_valid, aw_cnt} !== {3'b000, 32'd0}) begin
                miscompares++;
                $display("FAIL %s timeout_valids: aw_v=%b w_v=%b ar_v=%b aw_cnt=%0d want all 0",
                         name, axi_aw_valid, axi_w_valid, axi_ar_valid, aw_cnt);
            end
        end else begin
            vectors++;
            if ({aw_cnt, ar_cnt, w_cnt, r_cnt, w_bad} !==
                {32'd1, 32'd1, int'(len) + 1, int'(len) + 1, 32'd0}) begin
                miscompares++;
                $display("FAIL %s beat_counts: aw=%0d ar=%0d w=%0d r=%0d wbad=%0d want 1 1 %0d %0d 0",
                         name, aw_cnt, ar_cnt, w_cnt, r_cnt, w_bad, len + 1, len + 1);
            end
            for (int i = 0; i <= int'(len); i++) begin
                exp_data = seed + DW'(i);
                vectors++;
                if (mem[(int'(exp_addr) / SW + i) % 512] !== exp_data) begin
                    miscompares++;
                    $display("FAIL %s wdata[%0d]: got %h want %h", name, i,
                             mem[(int'(exp_addr) / SW + i) % 512], exp_data);
                end
            end
        end
    endtask

    task automatic check_outputs_zero(input string name);
        vectors++;
        if ({busy, done, error, err_count, axi_aw_valid, axi_w_valid, axi_b_ready,
             axi_ar_valid, axi_r_ready, axi_w_last} !== '0) begin
            miscompares++;
            $display("FAIL %s ctrl_zero: busy=%b done=%b err=%b cnt=%0d awv=%b wv=%b br=%b arv=%b rr=%b",
                     name, busy, done, error, err_count, axi_aw_valid, axi_w_valid,
                     axi_b_ready, axi_ar_valid, axi_r_ready);
        end
        vectors++;
        if ({axi_aw_addr, axi_aw_id, axi_aw_len, axi_ar_addr, axi_ar_id, axi_ar_len,
             axi_w_data} !== '0) begin
            miscompares++;
            $display("FAIL %s data_zero: aw_addr=%h aw_id=%h len=%h w_data=%h",
                     name, axi_aw_addr, axi_aw_id, axi_aw_len, axi_w_data);
        end
    endtask

    task automatic test_reset();
        slave_reset();
        axi_resetn = 1'b0;
        repeat (3) @(negedge axi_clk);
        check_outputs_zero("reset_hold");
        axi_resetn = 1'b1;
        repeat (2) @(negedge axi_clk);
        check_outputs_zero("reset_release");
    endtask

    task automatic test_single_beat();
        run_burst(12'h040, 8'd0, 64'h11, -1, 0, 0, 0, 0, "single_beat");
    endtask

    task automatic test_burst16();
        run_burst(12'h100, 8'd15, 64'hA5A5_0000_0000_0000, -1, 0, 0, 0, 0, "burst16");
    endtask

    task automatic test_seed_wrap();
        run_burst(12'h3F8, 8'd3, 64'hFFFF_FFFF_FFFF_FFFE, -1, 0, 0, 0, 0, "seed_wrap");
    endtask

    task automatic test_fault_inject();
        run_burst(12'h200, 8'd7, {$urandom, $urandom}, 2, 0, 0, 0, 0, "fault_inject");
    endtask

    task automatic test_bresp_error();
        run_burst(12'h080, 8'd2, {$urandom, $urandom}, -1, 0, 1, 0, 0, "bresp_error");
    endtask

    task automatic test_stall_timeout();
        run_burst(12'h300, 8'd4, 64'h1234, -1, 1100, 0, 0, 1, "stall_timeout");
    endtask

    task automatic test_reset_mid_read();
        bit in_rd;
        slave_reset();
        exp_addr = 12'h500; exp_len = 8'd15; exp_id = 8'h3C;
        @(negedge axi_clk);
        start = 1'b1; cfg_addr = 12'h500; cfg_len = 8'd15; cfg_id = 8'h3C;
        cfg_seed = {$urandom, $urandom};
        @(negedge axi_clk);
        start = 1'b0;
        in_rd = 0;
        for (int c = 0; (c < 3000) && !in_rd; c++) begin
            if (r_cnt >= 4) in_rd = 1;
            else begin
                slave_step();
                @(negedge axi_clk);
            end
        end
        vectors++;
        if (!in_rd) begin
            miscompares++;
            $display("FAIL reset_mid reach_read: only %0d read beats within 3000 cycles", r_cnt);
        end
        axi_resetn = 1'b0;
        #1;
        check_outputs_zero("reset_mid_read");
        slave_reset();
        repeat (2) @(negedge axi_clk);
        axi_resetn = 1'b1;
        @(negedge axi_clk);
        // Restart with spurious start pulses and scrambled cfg while busy.
        run_burst(12'h0A0, 8'd9, {$urandom, $urandom}, -1, 0, 0, 1, 0, "restart_noise");
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] a;
        logic [7:0]    l;
        int            cb;
        for (int k = 0; k < 6; k++) begin
            a  = AW'($urandom);
            l  = 8'($urandom_range(0, 31));
            cb = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 31)) : -1;
            run_burst(a, l, {$urandom, $urandom}, cb, 0, 0, 0, 0, "back_to_back");
        end
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_burst16();
        test_seed_wrap();
        test_fault_inject();
        test_bresp_error();
        test_stall_timeout();
        test_reset_mid_read();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
